// File: rtl/button_conditioner.sv
// button_conditioner
// Front end for the push-button PIO. Each raw active-low key is passed
// through a two-flop synchroniser, debounced by a consecutive-sample counter
// and tracked by a small per-button FSM that emits single-cycle press,
// release, long-press and (optionally) auto-repeat strobes.
//
// Optional feature: define BUTTON_CONDITIONER_AUTO_REPEAT_EN to enable the
// auto-repeat strobe in the HELD state. Without it repeat_pulse is tied low.
//
// Handshake/timing contract: there is no valid/ready handshake here. Every
// output is a registered level or a one-cycle strobe. btn_level_n and the
// matching press_pulse/release_pulse change on the same clock edge, and at
// most one strobe per button is high in any cycle (release has priority).
//
// FSM state per button is held in the `state` array (IDLE/PRESSED/HELD) so
// checkers can bind to it hierarchically.

module button_conditioner #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [N_BUTTONS-1:0] btn_raw_n,
  output logic [N_BUTTONS-1:0] btn_level_n,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_pulse,
  output logic [N_BUTTONS-1:0] repeat_pulse
);

  // Debounce counter only ever needs to count up to DEBOUNCE_CYCLES.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  // One hold counter serves both the long-press and the repeat timing.
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  // Terminal values: an event fires on the edge where the counter would
  // reach the configured length, so compare against length-1.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

  // Per-button FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  // Synchroniser stages.
  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;

  // Debounce state: btn_level_n itself is the registered stable level.
  logic [DW-1:0]        deb_cnt  [N_BUTTONS];
  logic [N_BUTTONS-1:0] disagree;
  logic [N_BUTTONS-1:0] accept;
  logic [N_BUTTONS-1:0] accept_press;
  logic [N_BUTTONS-1:0] accept_release;

  // Per-button FSM state and hold counter.
  logic [1:0]           state    [N_BUTTONS];
  logic [HW-1:0]        hold_cnt [N_BUTTONS];

  // Saturating increment so the hold counter can never wrap.
  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] value);
    if (value == HOLD_SAT) begin
      sat_inc = value;
    end else begin
      sat_inc = value + HW'(1);
    end
  endfunction

  // Two-flop synchroniser; idles at 1 (released) out of reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw_n;
      sync2 <= sync1;
    end
  end

  // Decide, per button, whether this edge accepts a new level.
  always_comb begin
    disagree       = '0;
    accept         = '0;
    accept_press   = '0;
    accept_release = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      disagree[i]       = sync2[i] ^ btn_level_n[i];
      accept[i]         = disagree[i] && (deb_cnt[i] == DEB_LAST);
      accept_press[i]   = accept[i] && !sync2[i];
      accept_release[i] = accept[i] &&  sync2[i];
    end
  end

  // Debounce: count consecutive disagreeing samples, flip the stable level
  // once DEBOUNCE_CYCLES of them have been seen, clear on any agreement.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      btn_level_n <= '1;
      for (int i = 0; i < N_BUTTONS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!disagree[i]) begin
          deb_cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_level_n[i] <= sync2[i];
          deb_cnt[i]     <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  // Per-button event FSM with auto-repeat while held.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        state[i]    <= ST_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (accept_press[i]) begin
              press_pulse[i] <= 1'b1;
              hold_cnt[i]    <= '0;
              state[i]       <= ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            // Release is checked first so it wins over a due long event.
            if (accept_release[i]) begin
              release_pulse[i] <= 1'b1;
              state[i]         <= ST_IDLE;
            end else if (hold_cnt[i] == LONG_LAST) begin
              long_pulse[i] <= 1'b1;
              hold_cnt[i]   <= '0;
              state[i]      <= ST_HELD;
            end else begin
              hold_cnt[i] <= sat_inc(hold_cnt[i]);
            end
          end
          ST_HELD: begin
            // Hold counter restarts after long and after every repeat.
            if (accept_release[i]) begin
              release_pulse[i] <= 1'b1;
              state[i]         <= ST_IDLE;
            end else if (hold_cnt[i] == REP_LAST) begin
              repeat_pulse[i] <= 1'b1;
              hold_cnt[i]     <= '0;
            end else begin
              hold_cnt[i] <= sat_inc(hold_cnt[i]);
            end
          end
          default: begin
            state[i]    <= ST_IDLE;
            hold_cnt[i] <= '0;
          end
        endcase
      end
    end
  end
`else
  // Per-button event FSM; HELD only waits for release.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        state[i]    <= ST_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (accept_press[i]) begin
              press_pulse[i] <= 1'b1;
              hold_cnt[i]    <= '0;
              state[i]       <= ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            // Release is checked first so it wins over a due long event.
            if (accept_release[i]) begin
              release_pulse[i] <= 1'b1;
              state[i]         <= ST_IDLE;
            end else if (hold_cnt[i] == LONG_LAST) begin
              long_pulse[i] <= 1'b1;
              hold_cnt[i]   <= '0;
              state[i]      <= ST_HELD;
            end else begin
              hold_cnt[i] <= sat_inc(hold_cnt[i]);
            end
          end
          ST_HELD: begin
            if (accept_release[i]) begin
              release_pulse[i] <= 1'b1;
              state[i]         <= ST_IDLE;
            end
          end
          default: begin
            state[i]    <= ST_IDLE;
            hold_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  // Auto-repeat compiled out.
  assign repeat_pulse = '0;
`endif

endmodule
